// File: rtl/bram_capture_arbiter_pkg.sv
// Shared types and constants for the capture arbiter in front of the block RAM write port.
package bram_capture_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  localparam logic [3:0] FULL_WORD_MASK = 4'hF;

endpackage

// File: rtl/bram_capture_arbiter_capture_fifo.sv
// Small synchronous FIFO buffering capture words ({address, data}) until an idle RAM write cycle.
module capture_fifo
  import bram_capture_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 45,
  parameter int unsigned DEPTH = 4
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             last
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  always_comb begin
    full    = (count == FULL_CNT);
    empty   = (count == '0);
    last    = (count == ONE_CNT);
    // Full is judged on the pre-pop count: no push-through when full.
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    rdata   = mem[rd_ptr];
  end

  always_ff @(posedge HCLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bram_capture_arbiter.sv
// Merges a 32-bit sample stream into the RAM write port behind the AHB RAM slave; bus writes always win.
module bram_capture_arbiter
  import bram_capture_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [ADDR_WIDTH-1:0] BUS_WRADDR,
  input  logic [31:0]           BUS_WDATA,
  input  logic [3:0]            BUS_WRITE,
  input  logic                  S_VALID,
  input  logic [31:0]           S_DATA,
  output logic                  S_READY,
  input  logic                  CFG_START,
  input  logic                  CFG_ABORT,
  input  logic                  CFG_CIRC,
  input  logic [ADDR_WIDTH-1:0] CFG_BASE,
  input  logic [ADDR_WIDTH:0]   CFG_LEN,
  output logic [ADDR_WIDTH-1:0] BRAM_WRADDR,
  output logic [31:0]           BRAM_WDATA,
  output logic [3:0]            BRAM_WRITE,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [ADDR_WIDTH:0]   WR_PTR
);

  localparam int unsigned WORD_W = ADDR_WIDTH + 32;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   acc_q;
  logic [ADDR_WIDTH:0]   wr_ptr_q;
  logic                  circ_q;
  logic                  done_q;

  logic                  bus_active;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_last;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [WORD_W-1:0]     push_word;
  logic [WORD_W-1:0]     head_word;
  logic [ADDR_WIDTH:0]   acc_next;
  logic [ADDR_WIDTH:0]   wr_ptr_next;

  always_comb begin
    bus_active  = |BUS_WRITE;
    S_READY     = (state_q == ST_CAPTURE) && !CFG_ABORT && !fifo_full &&
                  (circ_q || (acc_q < len_q));
    push        = S_VALID && S_READY;
    pop         = !bus_active && !fifo_empty;
    // acc_q doubles as the offset of the next accepted beat; the sum wraps at the top of RAM.
    cap_addr    = base_q + acc_q[ADDR_WIDTH-1:0];
    push_word   = {cap_addr, S_DATA};
    acc_next    = (circ_q && (acc_q == len_q - CNT_ONE)) ? '0 : acc_q + CNT_ONE;
    wr_ptr_next = (circ_q && (wr_ptr_q == len_q - CNT_ONE)) ? '0 : wr_ptr_q + CNT_ONE;
    BUSY        = (state_q != ST_IDLE);
    DONE        = done_q;
    WR_PTR      = wr_ptr_q;
  end

  always_comb begin
    BRAM_WRADDR = '0;
    BRAM_WDATA  = '0;
    BRAM_WRITE  = '0;
    if (bus_active) begin
      BRAM_WRADDR = BUS_WRADDR;
      BRAM_WDATA  = BUS_WDATA;
      BRAM_WRITE  = BUS_WRITE;
    end else if (!fifo_empty) begin
      BRAM_WRADDR = head_word[WORD_W-1:32];
      BRAM_WDATA  = head_word[31:0];
      BRAM_WRITE  = FULL_WORD_MASK;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      acc_q    <= '0;
      wr_ptr_q <= '0;
      circ_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (pop) begin
        wr_ptr_q <= wr_ptr_next;
      end
      case (state_q)
        ST_IDLE: begin
          if (CFG_START) begin
            if (CFG_LEN != '0) begin
              base_q   <= CFG_BASE;
              len_q    <= CFG_LEN;
              circ_q   <= CFG_CIRC;
              acc_q    <= '0;
              wr_ptr_q <= '0;
              done_q   <= 1'b0;
              state_q  <= ST_CAPTURE;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_CAPTURE: begin
          if (CFG_ABORT) begin
            state_q <= ST_DRAIN;
          end else if (push) begin
            acc_q <= acc_next;
            if (!circ_q && (acc_next == len_q)) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Leave as the final word retires, so DONE follows the last RAM write by one cycle.
          if (fifo_empty || (fifo_last && pop)) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  capture_fifo #(
    .WIDTH(WORD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_capture_fifo (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .push   (push),
    .wdata  (push_word),
    .pop    (pop),
    .rdata  (head_word),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .last   (fifo_last)
  );

endmodule

// File: tb/tb_bram_capture_arbiter.sv
// Scoreboard bench for bram_capture_arbiter: expected RAM writes queued by stimulus, checked by a monitor.
module tb_bram_capture_arbiter;

  localparam int unsigned AW = 13;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic [AW-1:0] BUS_WRADDR = '0;
  logic [31:0]   BUS_WDATA = '0;
  logic [3:0]    BUS_WRITE = '0;
  logic          S_VALID = 1'b0;
  logic [31:0]   S_DATA = '0;
  logic          S_READY;
  logic          CFG_START = 1'b0;
  logic          CFG_ABORT = 1'b0;
  logic          CFG_CIRC = 1'b0;
  logic [AW-1:0] CFG_BASE = '0;
  logic [AW:0]   CFG_LEN = '0;
  logic [AW-1:0] BRAM_WRADDR;
  logic [31:0]   BRAM_WDATA;
  logic [3:0]    BRAM_WRITE;
  logic          BUSY;
  logic          DONE;
  logic [AW:0]   WR_PTR;

  bram_capture_arbiter #(
    .ADDR_WIDTH(AW),
    .FIFO_DEPTH(4)
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .BUS_WRADDR (BUS_WRADDR),
    .BUS_WDATA  (BUS_WDATA),
    .BUS_WRITE  (BUS_WRITE),
    .S_VALID    (S_VALID),
    .S_DATA     (S_DATA),
    .S_READY    (S_READY),
    .CFG_START  (CFG_START),
    .CFG_ABORT  (CFG_ABORT),
    .CFG_CIRC   (CFG_CIRC),
    .CFG_BASE   (CFG_BASE),
    .CFG_LEN    (CFG_LEN),
    .BRAM_WRADDR(BRAM_WRADDR),
    .BRAM_WDATA (BRAM_WDATA),
    .BRAM_WRITE (BRAM_WRITE),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .WR_PTR     (WR_PTR)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;
  int acc_total = 0;
  logic [48:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] mask);
    exp_q.push_back({addr, data, mask});
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  // Waits until every queued write has been seen; returns just after the edge following the last one.
  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge HCLK);
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge HCLK);
    while (BUSY && n < 100) begin
      @(negedge HCLK);
      n++;
    end
    check(name, 64'(BUSY), 64'd0);
  endtask

  // Monitor: tracks stream handshakes and checks every RAM write against the queue head.
  initial begin
    logic [48:0] e;
    forever begin
      @(negedge HCLK);
      if (HRESETn) begin
        if (S_VALID && S_READY) acc_total++;
        if (BRAM_WRITE != 4'h0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", 64'({BRAM_WRADDR, BRAM_WDATA, BRAM_WRITE}), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("ram_write", 64'({BRAM_WRADDR, BRAM_WDATA, BRAM_WRITE}), 64'(e));
          end
        end
      end
    end
  end

  initial begin
    int acc0;
    logic [AW-1:0] circ_addr [7];
    circ_addr[0] = 13'h1FFE; circ_addr[1] = 13'h1FFF; circ_addr[2] = 13'h0000;
    circ_addr[3] = 13'h1FFE; circ_addr[4] = 13'h1FFF; circ_addr[5] = 13'h0000;
    circ_addr[6] = 13'h1FFE;

    // Reset values
    #2;
    check("rst_bram_write", 64'(BRAM_WRITE), 64'd0);
    check("rst_bram_addr_data", 64'({BRAM_WRADDR, BRAM_WDATA}), 64'd0);
    check("rst_flags", 64'({S_READY, BUSY, DONE}), 64'd0);
    check("rst_wr_ptr", 64'(WR_PTR), 64'd0);
    cyc(); cyc();
    HRESETn = 1'b1;
    cyc();

    // START with LEN=0: DONE next cycle, nothing written
    CFG_START = 1'b1; CFG_LEN = '0; CFG_BASE = 13'h123;
    cyc();
    CFG_START = 1'b0;
    @(negedge HCLK);
    check("len0_done", 64'(DONE), 64'd1);
    check("len0_busy", 64'(BUSY), 64'd0);
    repeat (3) cyc();

    // One-shot, bus idle
    for (int k = 0; k < 4; k++) expect_write(13'h100 + 13'(k), 32'hA0 + 32'(k), 4'hF);
    acc0 = acc_total;
    CFG_START = 1'b1; CFG_BASE = 13'h100; CFG_LEN = 14'd4; CFG_CIRC = 1'b0;
    S_VALID = 1'b1; S_DATA = 32'hA0;
    cyc();
    CFG_START = 1'b0;
    @(negedge HCLK);
    check("oneshot_busy_done", 64'({BUSY, DONE}), 64'b10);
    for (int n = 0; n < 50 && (acc_total - acc0) < 4; n++) begin
      cyc();
      S_DATA = 32'hA0 + 32'(acc_total - acc0);
    end
    S_VALID = 1'b0;
    wait_drain("oneshot_drain");
    @(negedge HCLK);
    check("oneshot_done", 64'({BUSY, DONE}), 64'b01);
    check("oneshot_wr_ptr", 64'(WR_PTR), 64'd4);
    cyc();

    // Bus priority with FIFO fill and ordered drain
    for (int i = 0; i < 6; i++) expect_write(13'h080 + 13'(i), 32'hCAFE0000 + 32'(i), 4'h3);
    for (int k = 0; k < 6; k++) expect_write(13'h200 + 13'(k), 32'hB0 + 32'(k), 4'hF);
    acc0 = acc_total;
    CFG_START = 1'b1; CFG_BASE = 13'h200; CFG_LEN = 14'd6;
    S_DATA = 32'hB0;
    cyc();
    CFG_START = 1'b0;
    S_VALID = 1'b1;
    for (int i = 0; i < 6; i++) begin
      BUS_WRITE = 4'h3; BUS_WRADDR = 13'h080 + 13'(i); BUS_WDATA = 32'hCAFE0000 + 32'(i);
      S_DATA = 32'hB0 + 32'(acc_total - acc0);
      @(negedge HCLK);
      if (i == 4) check("full_stall_ready", 64'(S_READY), 64'd0);
      cyc();
    end
    check("accepts_during_bus", 64'(acc_total - acc0), 64'd4);
    BUS_WRITE = 4'h0;
    for (int n = 0; n < 50 && (acc_total - acc0) < 6; n++) begin
      S_DATA = 32'hB0 + 32'(acc_total - acc0);
      cyc();
    end
    S_VALID = 1'b0;
    wait_drain("bus_prio_drain");
    @(negedge HCLK);
    check("bus_prio_done", 64'(DONE), 64'd1);
    check("bus_prio_wr_ptr", 64'(WR_PTR), 64'd6);
    cyc();

    // Circular wrap at the top of RAM, then abort
    for (int k = 0; k < 7; k++) expect_write(circ_addr[k], 32'hC0 + 32'(k), 4'hF);
    acc0 = acc_total;
    CFG_START = 1'b1; CFG_BASE = 13'h1FFE; CFG_LEN = 14'd3; CFG_CIRC = 1'b1;
    S_VALID = 1'b1; S_DATA = 32'hC0;
    cyc();
    CFG_START = 1'b0; CFG_CIRC = 1'b0;
    for (int n = 0; n < 50 && (acc_total - acc0) < 7; n++) begin
      cyc();
      S_DATA = 32'hC0 + 32'(acc_total - acc0);
    end
    S_VALID = 1'b0;
    CFG_ABORT = 1'b1;
    cyc();
    CFG_ABORT = 1'b0;
    wait_idle("circ_idle");
    check("circ_done", 64'(DONE), 64'd1);
    check("circ_wr_ptr", 64'(WR_PTR), 64'd1);
    check("circ_all_written", 64'(exp_q.size()), 64'd0);
    cyc();

    // Abort with a 3-word backlog while the bus is writing
    for (int i = 0; i < 6; i++) expect_write(13'h060 + 13'(i), 32'hBEEF0000 + 32'(i), 4'hF);
    for (int k = 0; k < 3; k++) expect_write(13'h300 + 13'(k), 32'hE0 + 32'(k), 4'hF);
    acc0 = acc_total;
    CFG_START = 1'b1; CFG_BASE = 13'h300; CFG_LEN = 14'd16;
    cyc();
    CFG_START = 1'b0;
    for (int i = 0; i < 6; i++) begin
      BUS_WRITE = 4'hF; BUS_WRADDR = 13'h060 + 13'(i); BUS_WDATA = 32'hBEEF0000 + 32'(i);
      S_VALID = (i < 4);
      CFG_ABORT = (i == 3);
      S_DATA = 32'hE0 + 32'(acc_total - acc0);
      @(negedge HCLK);
      if (i == 3) check("abort_ready_low", 64'(S_READY), 64'd0);
      if (i == 5) check("abort_not_done_yet", 64'(DONE), 64'd0);
      cyc();
    end
    BUS_WRITE = 4'h0; S_VALID = 1'b0; CFG_ABORT = 1'b0;
    check("abort_accepts", 64'(acc_total - acc0), 64'd3);
    wait_drain("abort_drain");
    @(negedge HCLK);
    check("abort_done", 64'({BUSY, DONE}), 64'b01);
    check("abort_wr_ptr", 64'(WR_PTR), 64'd3);
    cyc();

    // START while BUSY is ignored
    for (int k = 0; k < 2; k++) expect_write(13'h400 + 13'(k), 32'hF0 + 32'(k), 4'hF);
    acc0 = acc_total;
    CFG_START = 1'b1; CFG_BASE = 13'h400; CFG_LEN = 14'd2;
    cyc();
    CFG_BASE = 13'h700; CFG_LEN = 14'd5; CFG_CIRC = 1'b1;
    cyc();
    CFG_START = 1'b0; CFG_CIRC = 1'b0;
    S_VALID = 1'b1; S_DATA = 32'hF0;
    for (int n = 0; n < 50 && (acc_total - acc0) < 2; n++) begin
      cyc();
      S_DATA = 32'hF0 + 32'(acc_total - acc0);
    end
    S_VALID = 1'b0;
    wait_idle("restart_idle");
    check("restart_wr_ptr", 64'(WR_PTR), 64'd2);
    check("restart_all_written", 64'(exp_q.size()), 64'd0);
    cyc();

    // Reset mid-capture with a non-empty FIFO
    for (int i = 0; i < 3; i++) expect_write(13'h090 + 13'(i), 32'h11110000 + 32'(i), 4'hC);
    acc0 = acc_total;
    CFG_START = 1'b1; CFG_BASE = 13'h500; CFG_LEN = 14'd8;
    cyc();
    CFG_START = 1'b0;
    S_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      BUS_WRITE = 4'hC; BUS_WRADDR = 13'h090 + 13'(i); BUS_WDATA = 32'h11110000 + 32'(i);
      S_DATA = 32'h50 + 32'(acc_total - acc0);
      cyc();
    end
    check("rst_mid_accepts", 64'(acc_total - acc0), 64'd3);
    BUS_WRITE = 4'h0; S_VALID = 1'b0;
    HRESETn = 1'b0;
    #1;
    check("rst_mid_bram_write", 64'(BRAM_WRITE), 64'd0);
    check("rst_mid_addr_data", 64'({BRAM_WRADDR, BRAM_WDATA}), 64'd0);
    check("rst_mid_flags", 64'({S_READY, BUSY, DONE}), 64'd0);
    check("rst_mid_wr_ptr", 64'(WR_PTR), 64'd0);
    cyc(); cyc();
    HRESETn = 1'b1;
    repeat (6) cyc();
    check("post_rst_idle", 64'({BUSY, DONE}), 64'd0);
    check("post_rst_queue", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
